// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, sequencer state encoding and default operand width.
package alu_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2, HALT = 2'd3} state_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: command and response streams between a command source and the sequencer.
interface alu_if #(parameter int WIDTH = alu_pkg::WIDTH_DEF);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH:0]   rsp_data;
  logic             rsp_err;
  modport master (output cmd_valid, cmd_load, cmd_op, cmd_operand, rsp_ready,
                  input cmd_ready, rsp_valid, rsp_data, rsp_err);
  modport slave (input cmd_valid, cmd_load, cmd_op, cmd_operand, rsp_ready,
                 output cmd_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/ALU16bit.sv
// ALU16bit: combinational 16-bit ALU; add overflow raises err and forces the result to zero.
module ALU16bit
  import alu_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [2:0]  op,
  output logic [16:0] out,
  output logic        err
);
  logic [16:0] sum;
  assign sum = {1'b0, x} + {1'b0, y};
  assign err = op == OP_ADD && sum[16];
  assign out = op == OP_ADD ? (sum[16] ? 17'd0 : sum) :
               op == OP_SUB ? {1'b0, x} - {1'b0, y} :
               op == OP_SHL ? {x, 1'b0} :
               op == OP_SHR ? {2'b0, x[15:1]} :
               op == OP_AND ? {1'b0, x & y} :
               op == OP_OR  ? {1'b0, x | y} :
               op == OP_XOR ? {1'b0, x ^ y} : {1'b0, ~x};
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready command front-end driving the ALU from a 17-bit running accumulator.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  alu_if.slave             bus,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_op,
  input  logic [WIDTH:0]   alu_out,
  input  logic             alu_err,
  output logic             halted,
  output logic [CNT_W-1:0] op_count
);
  state_t         state;
  logic [WIDTH:0] acc;
  logic           rsp_valid;
  logic           rsp_err;
  assign bus.cmd_ready = state == IDLE || state == HALT;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = acc;
  assign bus.rsp_err   = rsp_err;
  assign alu_x         = acc[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      alu_y     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      halted    <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE, HALT: if (bus.cmd_valid) begin
          if (bus.cmd_load) begin
            acc       <= {1'b0, bus.cmd_operand};
            halted    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (state == HALT) begin
            // rejected while halted: no ALU activity, only an error response
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            alu_y  <= bus.cmd_operand;
            alu_op <= bus.cmd_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          acc       <= alu_out;
          rsp_err   <= alu_err;
          halted    <= alu_err;
          op_count  <= op_count + 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= halted ? HALT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus randomized checks of the sequencer against a behavioural model.
module tb_alu_sequencer;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] alu_x, alu_y;
  logic [2:0]  alu_op;
  logic [16:0] alu_out;
  logic        alu_err, halted;
  logic [7:0]  op_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [16:0] m_acc;
  logic        m_halt;
  logic [7:0]  m_cnt;
  logic [16:0] last_data;
  logic        last_err;

  always #5 clk = ~clk;

  alu_if bus ();

  alu_sequencer dut (
    .clk(clk), .clear(clear), .bus(bus),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_out(alu_out), .alu_err(alu_err),
    .halted(halted), .op_count(op_count)
  );

  ALU16bit alu (.x(alu_x), .y(alu_y), .op(alu_op), .out(alu_out), .err(alu_err));

  function automatic logic [17:0] alu_ref(input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
    int unsigned a = x;
    int unsigned b = y;
    int unsigned r;
    logic e = 1'b0;
    case (op)
      3'd0: begin r = a + b; e = r > 65535; if (e) r = 0; end
      3'd1: r = a - b;
      3'd2: r = a * 2;
      3'd3: r = a / 2;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 65535 - a;
    endcase
    return {e, r[16:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_halt = 1'b0;
    m_cnt = '0;
  endtask

  task automatic send(input logic ld, input logic [2:0] op, input logic [15:0] v, input int hold);
    logic [17:0] r;
    logic        exp_err;
    int          n;
    int          exp_lat;
    bus.cmd_valid = 1'b1;
    bus.cmd_load = ld;
    bus.cmd_op = op;
    bus.cmd_operand = v;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin tick(); n++; end
    check("cmd_ready", 32'(bus.cmd_ready), 1);
    exp_lat = (ld || m_halt) ? 1 : 2;
    exp_err = 1'b0;
    if (ld) begin
      m_acc = {1'b0, v};
      m_halt = 1'b0;
    end else if (m_halt) begin
      exp_err = 1'b1;
    end else begin
      r = alu_ref(m_acc[15:0], v, op);
      m_acc = r[16:0];
      exp_err = r[17];
      m_halt = r[17];
      m_cnt++;
    end
    tick();
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    check("rsp_latency", n, exp_lat);
    check("rsp_data", 32'(bus.rsp_data), 32'(m_acc));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("halted", 32'(halted), 32'(m_halt));
    check("op_count", 32'(op_count), 32'(m_cnt));
    last_data = bus.rsp_data;
    last_err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_load = 1'b1;
      bus.cmd_operand = 16'h1234;
      tick();
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_data", 32'(bus.rsp_data), 32'(m_acc));
      check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_drop", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_load = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_operand = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    tick();
    tick();
    clear = 1'b0;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_alu_x", 32'(alu_x), 0);

    send(1'b1, OP_ADD, 16'h00E1, 0);
    check("tp_load", 32'(last_data), 32'h000E1);
    send(1'b0, OP_ADD, 16'h0B01, 0);
    check("tp_add", 32'(last_data), 32'h00BE2);
    check("tp_add_cnt", 32'(op_count), 1);
    send(1'b0, OP_SHL, 16'h0000, 0);
    check("tp_shl", 32'(last_data), 32'h017C4);
    send(1'b0, OP_SHR, 16'h0000, 0);
    check("tp_shr", 32'(last_data), 32'h00BE2);
    check("tp_shr_cnt", 32'(op_count), 3);

    send(1'b1, OP_ADD, 16'h0001, 0);
    send(1'b0, OP_ADD, 16'hFFFF, 0);
    check("ovf_err", 32'(last_err), 1);
    check("ovf_data", 32'(last_data), 0);
    check("ovf_halted", 32'(halted), 1);
    send(1'b0, OP_SUB, 16'h0001, 0);
    check("halt_rej_err", 32'(last_err), 1);
    check("halt_rej_data", 32'(last_data), 0);
    check("halt_rej_op", 32'(alu_op), 32'(OP_ADD));
    check("halt_rej_cnt", 32'(op_count), 4);
    send(1'b1, OP_ADD, 16'h0005, 0);
    check("halt_load_err", 32'(last_err), 0);
    check("halt_load_halted", 32'(halted), 0);

    send(1'b0, OP_XOR, 16'h00FF, 3);
    check("hold_result", 32'(last_data), 32'h000FA);
    send(1'b0, OP_OR, 16'h0100, 0);
    check("after_hold", 32'(last_data), 32'h001FA);

    bus.cmd_valid = 1'b1;
    bus.cmd_load = 1'b0;
    bus.cmd_op = OP_ADD;
    bus.cmd_operand = 16'h0007;
    tick();
    bus.cmd_valid = 1'b0;
    check("exec_busy", 32'(bus.cmd_ready), 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    check("clr_cmd_ready", 32'(bus.cmd_ready), 1);
    check("clr_rsp_valid", 32'(bus.rsp_valid), 0);
    check("clr_acc", 32'(bus.rsp_data), 0);
    check("clr_op_count", 32'(op_count), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_no_rsp", 32'(bus.rsp_valid), 0);
    end

    for (int i = 0; i < 60; i++)
      send($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 2));

    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++)
      send(1'b0, OP_AND, 16'($urandom), 0);
    check("wrap_op_count", 32'(op_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
